// File: rtl/ripple_carry_counter_pkg.sv
// Shared constants for the ripple counter: default width and reset-active level.
package ripple_carry_counter_pkg;
    localparam int   COUNTER_WIDTH = 4;
    localparam logic RESET_ACTIVE  = 1'b0;
endpackage

// File: rtl/ripple_carry_counter_if.sv
// Count bus of the ripple counter; the counter drives, observers sample.
interface ripple_carry_counter_if #(
    parameter int WIDTH = ripple_carry_counter_pkg::COUNTER_WIDTH
);
    logic [WIDTH-1:0] q;

    modport master (output q);
    modport slave  (input  q);
endinterface

// File: rtl/ripple_carry_counter_t_ff.sv
// Negative-edge toggle flip-flop with asynchronous active-low clear.
module t_ff
    import ripple_carry_counter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    output logic q
);
    logic d;

    // D flop closed on its own inverted output gives the toggle.
    assign d = ~q;

    always_ff @(negedge clk or negedge rst_n) begin
        if (rst_n == RESET_ACTIVE) q <= 1'b0;
        else                       q <= d;
    end
endmodule

// File: rtl/ripple_carry_counter.sv
// Asynchronous up counter: each stage is clocked by the falling edge of the
// stage below it, so the carry ripples rather than sharing one clock.
module ripple_carry_counter
    import ripple_carry_counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
);
    for (genvar g = 0; g < WIDTH; g++) begin : g_stage
        if (g == 0) begin : g_lsb
            t_ff u_tff (.clk(clk),      .rst_n(reset), .q(q[g]));
        end else begin : g_up
            // Reset holds every stage clear, so falling bits under reset
            // cannot advance the stage above.
            t_ff u_tff (.clk(q[g-1]),   .rst_n(reset), .q(q[g]));
        end
    end
endmodule

// File: tb/tb_ripple_carry_counter.sv
// Randomized bench for the ripple counter at widths 4, 1 and 8 against a
// falling-edge-count reference model.
`timescale 1ns/1ps
module tb_ripple_carry_counter;
    logic clk;
    logic reset;

    ripple_carry_counter_if #(.WIDTH(4)) cif4 ();
    ripple_carry_counter_if #(.WIDTH(1)) cif1 ();
    ripple_carry_counter_if #(.WIDTH(8)) cif8 ();

    ripple_carry_counter #(.WIDTH(4)) u_dut4 (.clk(clk), .reset(reset), .q(cif4.q));
    ripple_carry_counter #(.WIDTH(1)) u_dut1 (.clk(clk), .reset(reset), .q(cif1.q));
    ripple_carry_counter #(.WIDTH(8)) u_dut8 (.clk(clk), .reset(reset), .q(cif8.q));

    int errs   = 0;
    int checks = 0;
    int edges  = 0;   // falling clk edges seen since the last reset release

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Reference: count = falling edges since release, modulo 2^WIDTH.
    always @(negedge clk) if (reset === 1'b1) edges = edges + 1;
    always @(negedge reset) edges = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_w4"}, 32'(cif4.q), 32'(edges % 16));
        chk({tag, "_w1"}, 32'(cif1.q), 32'(edges % 2));
        chk({tag, "_w8"}, 32'(cif8.q), 32'(edges % 256));
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #45 chk_all("settled");
            #10 chk_all("after_rise");
        end
    endtask

    task automatic reset_pulse();
        int d;
        d = $urandom_range(10, 80);
        @(negedge clk);
        #(d) reset = 1'b0;
        #2 chk({"pulse_w4"}, 32'(cif4.q), 32'd0);
        chk("pulse_w1", 32'(cif1.q), 32'd0);
        chk("pulse_w8", 32'(cif8.q), 32'd0);
        #2 reset = 1'b1;
        #1 chk_all("released");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        for (int t = 0; t < 4; t++) begin
            #38 chk_all("por");
        end
        #8 reset = 1'b1;               // release at 160 ns
        #5 chk_all("deassert_nochg");

        // First falling edge after release at 200 ns gives 1.
        @(negedge clk);
        #1 chk("first_edge_w4", 32'(cif4.q), 32'd1);

        // Free count through 15, wrap to 0, then 1; covers 7->8.
        run_cycles(19);

        for (int k = 0; k < 6; k++) begin
            reset_pulse();
            run_cycles($urandom_range(1, 20));
        end

        reset_pulse();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            #45 chk("long_w8", 32'(cif8.q), 32'(edges % 256));
        end
        chk("w8_full_wrap", 32'(cif8.q), 32'd0);
        chk("w4_full_wrap", 32'(cif4.q), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
